// File: rtl/i2c_alu_target.sv
// I2C target exposing ALU operands (A, B, Cin) and results (Sum1, Sum2) as a register file.
// Optional 3-sample majority filter on SCL/SDA when I2C_ALU_GLITCH_FILTER_EN is defined.
module i2c_alu_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  output logic       cin_o,
  input  logic [7:0] sum1_i,
  input  logic [7:0] sum2_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_c, sda_c, scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_ALU_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;
  logic       scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_s};
      sda_hist_q <= {sda_hist_q[0], sda_s};
      scl_flt_q  <= (scl_s & scl_hist_q[0]) | (scl_s & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
      sda_flt_q  <= (sda_s & sda_hist_q[0]) | (sda_s & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       cin_q, cin_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic [7:0] rd_data, rx_byte;

  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      8'h00:   rd_data = a_q;
      8'h01:   rd_data = b_q;
      8'h02:   rd_data = {7'b0, cin_q};
      8'h03:   rd_data = sum1_i;
      8'h04:   rd_data = sum2_i;
      default: rd_data = 8'h00;
    endcase
  end

  assign rx_byte = {shift_q[6:0], sda_c};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    ack_d     = ack_q;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Commit on the 8th rise so the ALU sees the operand before the ACK slot.
            if (state_q == WDATA && bit_cnt_q == 4'd7) begin
              case (ptr_q)
                8'h00:   a_d   = rx_byte;
                8'h01:   b_d   = rx_byte;
                8'h02:   cin_d = rx_byte[0];
                default: ;
              endcase
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR && shift_q[7:1] != TARGET_ADDR) begin
              state_d = WAIT;
            end else begin
              oe_d = 1'b1;
              case (state_q)
                ADDR:    state_d = ADDR_ACK;
                REG:     begin state_d = REG_ACK; ptr_d = shift_q; end
                default: state_d = WDATA_ACK;
              endcase
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == ADDR_ACK && shift_q[0]) begin
              state_d = RDATA;
              tx_d    = {rd_data[6:0], 1'b0};
              oe_d    = ~rd_data[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = REG;
            end else begin
              state_d = WDATA;
              if (state_q == WDATA_ACK) ptr_d = ptr_q + 8'd1;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RDATA_ACK;
            end else begin
              oe_d = ~tx_q[7];
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = ~sda_c;
            if (~sda_c) ptr_d = ptr_q + 8'd1;
          end else if (scl_fall) begin
            if (ack_q) begin
              state_d = RDATA;
              tx_d    = {rd_data[6:0], 1'b0};
              oe_d    = ~rd_data[7];
            end else begin
              state_d = WAIT;
              oe_d    = 1'b0;
            end
          end
        end
        WAIT:    oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      ptr_q     <= 8'h00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      cin_q     <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign sda_oe = oe_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign cin_o  = cin_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_i2c_alu_target.sv
// Bench for i2c_alu_target: bit-banged I2C controller plus a register-map reference model.
module tb_i2c_alu_target;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1, sda_drv = 1'b1, glitch = 1'b0;
  logic       scl_i, sda_i, sda_oe, cin_o, busy_o;
  logic [7:0] a_o, b_o, sum1_i = 8'h00, sum2_i = 8'h00;

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic       m_cin = 1'b0;

  always #5 clk = ~clk;

  assign scl_i = scl_drv;
  assign sda_i = glitch ? 1'b0 : (sda_drv & ~sda_oe);

  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (busy_o === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  i2c_alu_target dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .a_o(a_o), .b_o(b_o), .cin_o(cin_o), .sum1_i(sum1_i), .sum2_i(sum2_i),
    .busy_o(busy_o)
  );

  // Reference register map
  function automatic logic [7:0] model_rd(input logic [7:0] p);
    if (p == 8'd0) return m_a;
    if (p == 8'd1) return m_b;
    if (p == 8'd2) return {7'd0, m_cin};
    if (p == 8'd3) return sum1_i;
    if (p == 8'd4) return sum2_i;
    return 8'h00;
  endfunction

  task automatic model_burst(input logic [7:0] ptr);
    logic [7:0] p = ptr;
    foreach (wq[i]) begin
      if (p == 8'd0) m_a = wq[i];
      else if (p == 8'd1) m_b = wq[i];
      else if (p == 8'd2) m_cin = wq[i][0];
      p = p + 8'd1;
    end
  endtask

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; qw(); scl_drv = 1'b1; qw(); sda_drv = 1'b0; qw(); scl_drv = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; qw(); scl_drv = 1'b1; qw(); sda_drv = 1'b1; qw();
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_drv = b; qw(); scl_drv = 1'b1; qw(); r = sda_i; qw(); scl_drv = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic last, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(last, r);
  endtask

  task automatic write_frame(input logic [7:0] addr_byte, input logic [7:0] ptr, output int acks);
    logic ack;
    acks = 0;
    i2c_start();
    write_byte(addr_byte, ack); acks += int'(ack);
    write_byte(ptr, ack);       acks += int'(ack);
    foreach (wq[i]) begin
      write_byte(wq[i], ack); acks += int'(ack);
    end
    i2c_stop();
  endtask

  // Leaves the bus in WAIT after the final NACK; caller issues STOP.
  task automatic read_frame(input logic [7:0] ptr, input int n, output int acks);
    logic ack;
    logic [7:0] d;
    acks = 0;
    rq.delete();
    i2c_start();
    write_byte(8'h84, ack); acks += int'(ack);
    write_byte(ptr, ack);   acks += int'(ack);
    i2c_start();
    write_byte(8'h85, ack); acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rq.push_back(d);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", sda_oe); end
    if (a_o !== 8'h00) begin errors++; $display("FAIL reset_a got %h want 00", a_o); end
    if (b_o !== 8'h00) begin errors++; $display("FAIL reset_b got %h want 00", b_o); end
    if (cin_o !== 1'b0) begin errors++; $display("FAIL reset_cin got %b want 0", cin_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int acks;
    wq = '{8'h0A, 8'h05, 8'h01};
    write_frame(8'h84, 8'h00, acks);
    model_burst(8'h00);
    repeat (4) @(negedge clk);
    checks += 5;
    if (acks != 5) begin errors++; $display("FAIL write_acks got %0d want 5", acks); end
    if (a_o !== m_a) begin errors++; $display("FAIL write_a got %h want %h", a_o, m_a); end
    if (b_o !== m_b) begin errors++; $display("FAIL write_b got %h want %h", b_o, m_b); end
    if (cin_o !== m_cin) begin errors++; $display("FAIL write_cin got %b want %b", cin_o, m_cin); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL write_busy got %b want 0", busy_o); end
  endtask

  task automatic test_read();
    int acks;
    sum1_i = 8'h10; sum2_i = 8'h00;
    read_frame(8'h03, 2, acks);
    checks += 5;
    if (acks != 3) begin errors++; $display("FAIL read_acks got %0d want 3", acks); end
    if (rq[0] !== 8'h10) begin errors++; $display("FAIL read_b0 got %h want 10", rq[0]); end
    if (rq[1] !== 8'h00) begin errors++; $display("FAIL read_b1 got %h want 00", rq[1]); end
    if (busy_o !== 1'b1 || sda_oe !== 1'b0)
      begin errors++; $display("FAIL read_wait busy/oe got %b/%b want 1/0", busy_o, sda_oe); end
    i2c_stop();
    repeat (4) @(negedge clk);
    if (busy_o !== 1'b0) begin errors++; $display("FAIL read_idle busy got %b want 0", busy_o); end
  endtask

  task automatic test_mismatch();
    int acks, oe0;
    oe0 = oe_cnt;
    wq = '{8'hFF};
    write_frame(8'h86, 8'h00, acks);
    repeat (4) @(negedge clk);
    checks += 3;
    if (oe_cnt != oe0) begin errors++; $display("FAIL mismatch_oe got %0d cycles want 0", oe_cnt - oe0); end
    if (acks != 0) begin errors++; $display("FAIL mismatch_acks got %0d want 0", acks); end
    if (a_o !== m_a) begin errors++; $display("FAIL mismatch_a got %h want %h", a_o, m_a); end
  endtask

  task automatic test_wrap_ro();
    int acks;
    sum1_i = 8'($urandom); sum2_i = 8'($urandom);
    wq = '{8'h55, 8'h66, 8'h77};
    write_frame(8'h84, 8'h03, acks);
    model_burst(8'h03);
    checks += 2;
    if (acks != 5) begin errors++; $display("FAIL ro_acks got %0d want 5", acks); end
    if (a_o !== m_a || b_o !== m_b || cin_o !== m_cin)
      begin errors++; $display("FAIL ro_regs got %h %h %b want %h %h %b", a_o, b_o, cin_o, m_a, m_b, m_cin); end
    read_frame(8'h03, 3, acks);
    i2c_stop();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rq[i] !== model_rd(8'(3 + i)))
        begin errors++; $display("FAIL ro_read%0d got %h want %h", i, rq[i], model_rd(8'(3 + i))); end
    end
    wq = '{8'hFF};
    write_frame(8'h84, 8'h02, acks);
    model_burst(8'h02);
    read_frame(8'h02, 1, acks);
    i2c_stop();
    checks++;
    if (rq[0] !== 8'h01) begin errors++; $display("FAIL cin_read got %h want 01", rq[0]); end
    wq = '{8'h12, 8'h34};
    write_frame(8'h84, 8'hFF, acks);
    model_burst(8'hFF);
    repeat (4) @(negedge clk);
    checks += 2;
    if (acks != 4) begin errors++; $display("FAIL wrap_acks got %0d want 4", acks); end
    if (a_o !== m_a) begin errors++; $display("FAIL wrap_a got %h want %h", a_o, m_a); end
  endtask

  task automatic test_abort();
    logic ack, r;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) xfer_bit(~m_a[7 - i], r);
    i2c_stop();
    repeat (4) @(negedge clk);
    checks += 2;
    if (a_o !== m_a) begin errors++; $display("FAIL abort_a got %h want %h", a_o, m_a); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
  endtask

  task automatic test_random();
    int acks, n;
    logic [7:0] p0;
    for (int it = 0; it < 4; it++) begin
      wq = '{8'($urandom), 8'($urandom), 8'($urandom)};
      write_frame(8'h84, 8'h00, acks);
      model_burst(8'h00);
      repeat (4) @(negedge clk);
      checks++;
      if (a_o !== m_a || b_o !== m_b || cin_o !== m_cin || acks != 5)
        begin errors++; $display("FAIL rand_wr%0d got %h %h %b acks %0d want %h %h %b acks 5", it, a_o, b_o, cin_o, acks, m_a, m_b, m_cin); end
      sum1_i = 8'($urandom); sum2_i = 8'($urandom);
      p0 = 8'($urandom_range(0, 3));
      n = 3;
      read_frame(p0, n, acks);
      i2c_stop();
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rq[i] !== model_rd(p0 + 8'(i)))
          begin errors++; $display("FAIL rand_rd%0d_%0d got %h want %h", it, i, rq[i], model_rd(p0 + 8'(i))); end
      end
    end
  endtask

  task automatic test_glitch();
    int b0;
    logic exp_start;
`ifdef I2C_ALU_GLITCH_FILTER_EN
    exp_start = 1'b0;
`else
    exp_start = 1'b1;
`endif
    scl_drv = 1'b1; sda_drv = 1'b1;
    repeat (10) @(negedge clk);
    b0 = busy_cnt;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ((busy_cnt != b0) !== exp_start)
      begin errors++; $display("FAIL glitch_start got %b want %b", busy_cnt != b0, exp_start); end
  endtask

  task automatic test_reset_rdata();
    int acks, cyc;
    logic ack;
    wq = '{8'h0A};
    write_frame(8'h84, 8'h00, acks);
    model_burst(8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h85, ack);
    cyc = 0;
    while (sda_oe !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL rdata_drive got %b want 1", sda_oe); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL async_rst_oe got %b want 0", sda_oe); end
    scl_drv = 1'b1; sda_drv = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (a_o !== 8'h00 || busy_o !== 1'b0)
      begin errors++; $display("FAIL post_rst got a=%h busy=%b want 00/0", a_o, busy_o); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap_ro();
    test_abort();
    test_random();
    test_glitch();
    test_reset_rdata();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
